// File: rtl/sp3_mux_tx.sv
`default_nettype none
// ============================================================================
// Module   : sp3_mux_tx
// Brief    : SP3 link transmit emulator. Buffers A/B word pairs in a small
//            FIFO and interleaves them A-slot / B-slot onto one MGT TX word
//            stream, with per-channel bitslip injection and idle fill on
//            underflow.
// Revision : 1.0 - initial release
// ============================================================================
module sp3_mux_tx #(
   parameter int                WORD_W     = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [WORD_W-1:0] IDLE_WORD  = 32'hAAAA_AAAA
) (
   input  logic                              mgtclk,
   input  logic                              reset,
   input  logic [WORD_W-1:0]                 word_a_i,
   input  logic [WORD_W-1:0]                 word_b_i,
   input  logic                              pair_valid_i,
   output logic                              pair_ready_o,
   input  logic                              bitslip_a_i,
   input  logic                              bitslip_b_i,
   output logic [WORD_W-1:0]                 mgtword_o,
   output logic                              slot_b_o,
   output logic                              underflow_o,
   output logic [$clog2(WORD_W)-1:0]         slip_a_o,
   output logic [$clog2(WORD_W)-1:0]         slip_b_o,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_SW = $clog2(WORD_W);
   localparam int c_LW = c_AW + 1;
   localparam logic [c_SW-1:0] c_SLIP_MAX = c_SW'(WORD_W - 1);

   typedef enum logic [0:0] {
      SLOT_A = 1'b0,
      SLOT_B = 1'b1
   } slot_t;

   slot_t             r_slot;
   slot_t             w_slot_nxt;

   logic [WORD_W-1:0] r_mem_a [FIFO_DEPTH];
   logic [WORD_W-1:0] r_mem_b [FIFO_DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_LW-1:0]   r_level;

   logic [WORD_W-1:0] r_hold_b;
   logic [WORD_W-1:0] r_prev_a;
   logic [WORD_W-1:0] r_prev_b;
   logic [c_SW-1:0]   r_slip_a;
   logic [c_SW-1:0]   r_slip_b;
   logic              r_pend_a;
   logic              r_pend_b;
   logic [WORD_W-1:0] r_mgtword;
   logic              r_slot_b_out;
   logic              r_underflow;

   logic              w_push;
   logic              w_pop;
   logic [WORD_W-1:0] w_cur_a;
   logic [WORD_W-1:0] w_cur_b;
   logic [c_SW-1:0]   w_slip_a_nxt;
   logic [c_SW-1:0]   w_slip_b_nxt;
   logic [WORD_W-1:0] w_emit_word;

   // Delay a channel stream by s bits: the low s output bits come from the
   // top of the previous word of the same channel, so the stream stays
   // continuous across word boundaries.
   function automatic logic [WORD_W-1:0] f_slip(
      input logic [WORD_W-1:0] cur,
      input logic [WORD_W-1:0] prev,
      input logic [c_SW-1:0]   s
   );
      logic [2*WORD_W-1:0] cat;
      cat = {cur, prev} >> (WORD_W - int'(s));
      return cat[WORD_W-1:0];
   endfunction

   assign pair_ready_o = (r_level < c_LW'(FIFO_DEPTH));
   assign w_push       = pair_valid_i && pair_ready_o;
   // Pop decision uses the level at cycle start, so a pair pushed into an
   // empty FIFO is never popped in the same cycle.
   assign w_pop        = (r_slot == SLOT_A) && (r_level != '0);

   assign w_cur_a = w_pop ? r_mem_a[r_rd_ptr] : IDLE_WORD;
   assign w_cur_b = r_hold_b;

   // A pending slip is consumed (and used) by the channel's next emission.
   assign w_slip_a_nxt = !r_pend_a ? r_slip_a :
                         (r_slip_a == c_SLIP_MAX) ? '0 : r_slip_a + 1'b1;
   assign w_slip_b_nxt = !r_pend_b ? r_slip_b :
                         (r_slip_b == c_SLIP_MAX) ? '0 : r_slip_b + 1'b1;

   assign w_emit_word = (r_slot == SLOT_B) ? f_slip(w_cur_b, r_prev_b, w_slip_b_nxt)
                                           : f_slip(w_cur_a, r_prev_a, w_slip_a_nxt);

   // Slot sequencer state register.
   always_ff @(posedge mgtclk or posedge reset) begin
      if (reset) r_slot <= SLOT_A;
      else       r_slot <= w_slot_nxt;
   end

   // Slot sequencer next state: strict A/B alternation.
   always_comb begin
      w_slot_nxt = SLOT_A;
      if (r_slot == SLOT_A) w_slot_nxt = SLOT_B;
   end

   // FIFO storage; contents need no reset since the level gates every read.
   always_ff @(posedge mgtclk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= word_a_i;
         r_mem_b[r_wr_ptr] <= word_b_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge mgtclk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Output word, per-channel history, slip counters and pending slips.
   always_ff @(posedge mgtclk or posedge reset) begin
      if (reset) begin
         r_mgtword    <= IDLE_WORD;
         r_slot_b_out <= 1'b1;
         r_underflow  <= 1'b0;
         r_hold_b     <= IDLE_WORD;
         r_prev_a     <= IDLE_WORD;
         r_prev_b     <= IDLE_WORD;
         r_slip_a     <= '0;
         r_slip_b     <= '0;
         r_pend_a     <= 1'b0;
         r_pend_b     <= 1'b0;
      end else begin
         r_mgtword <= w_emit_word;
         if (r_slot == SLOT_A) begin
            r_slot_b_out <= 1'b0;
            r_underflow  <= !w_pop;
            r_hold_b     <= w_pop ? r_mem_b[r_rd_ptr] : IDLE_WORD;
            r_prev_a     <= w_cur_a;
            r_slip_a     <= w_slip_a_nxt;
            // A pulse in the emitting cycle belongs to the next emission.
            r_pend_a     <= bitslip_a_i;
            r_pend_b     <= r_pend_b | bitslip_b_i;
         end else begin
            r_slot_b_out <= 1'b1;
            r_underflow  <= 1'b0;
            r_prev_b     <= w_cur_b;
            r_slip_b     <= w_slip_b_nxt;
            r_pend_b     <= bitslip_b_i;
            r_pend_a     <= r_pend_a | bitslip_a_i;
         end
      end
   end

   assign mgtword_o    = r_mgtword;
   assign slot_b_o     = r_slot_b_out;
   assign underflow_o  = r_underflow;
   assign slip_a_o     = r_slip_a;
   assign slip_b_o     = r_slip_b;
   assign fifo_level_o = r_level;

endmodule
`default_nettype wire

// File: doc/sp3_mux_tx.md
Name: sp3_mux_tx

Overview:
Transmit-side counterpart of the SPROCKET3 dual receiver, used as an FPGA-side emulator/loopback source for SP3 link bring-up. It accepts A/B channel word pairs through a ready/valid FIFO and time-interleaves them word-by-word into one 320 MHz MGT TX word stream (A slot, then B slot). Per-channel bitslip injection (0..31 bit stream delay) exercises receiver frame alignment. Underflow inserts an idle pattern.

Parameters:
WORD_W, 32, MGT word width; bitslip range 0..WORD_W-1
FIFO_DEPTH, 4, pair FIFO depth; power of two, >=2
IDLE_WORD, 32'hAAAA_AAAA, word emitted on both channels during underflow and after reset

Ports:
mgtclk  in  1  single clock, MGT TX word clock (320 MHz)
reset  in  1  asynchronous, active-high; clears all state
word_a_i  in  WORD_W  channel A word of offered pair
word_b_i  in  WORD_W  channel B word of offered pair
pair_valid_i  in  1  pair offered
pair_ready_o  out  1  FIFO can accept; pair accepted when valid&&ready
bitslip_a_i  in  1  pulse: delay channel A stream by one more bit
bitslip_b_i  in  1  pulse: delay channel B stream by one more bit
mgtword_o  out  WORD_W  interleaved TX word, registered
slot_b_o  out  1  1 = mgtword_o carries B word, 0 = A word
underflow_o  out  1  one-cycle pulse, aligned with the A word of an idle pair
slip_a_o  out  5  current channel A slip count
slip_b_o  out  5  current channel B slip count
fifo_level_o  out  clog2(FIFO_DEPTH)+1  pairs stored

Behaviour:
- Reset values: mgtword_o=IDLE_WORD, slot_b_o=1, underflow_o=0, slip_a/b_o=0, fifo_level_o=0, pair_ready_o=1; internal slot=A, hold_b=IDLE_WORD, prev_a=prev_b=IDLE_WORD, pending slips cleared.
- Reset asserted mid-operation: FIFO flushed, in-flight held B word discarded, slips zeroed; first A slot after deassertion is the first mgtclk edge.
- Slot register toggles every cycle: A, B, A, B...
- FIFO: pair_ready_o = (level < FIFO_DEPTH), combinational from registered level. Push on valid&&ready. Pop only in A slot when level>0 at cycle start. Push and pop in same cycle: level unchanged. Push into empty FIFO is not popped the same cycle.
- A slot, FIFO non-empty: mgtword_o <= shiftA(head.a); hold_b <= head.b; underflow_o <= 0; pop.
- A slot, FIFO empty: mgtword_o <= shiftA(IDLE_WORD); hold_b <= IDLE_WORD; underflow_o <= 1.
- B slot: mgtword_o <= shiftB(hold_b); underflow_o <= 0.
- slot_b_o registered with mgtword_o; it is 0 on A words and 1 on B words.
- Latency: pair accepted at edge t with empty FIFO appears in mgtword_o at the first A-slot edge >= t+1. The matching B word appears one cycle later.
- Shift per channel c, with current word cur and slip s:
  - out = bits [WORD_W-1:0] of ({cur, prev_c} >> (WORD_W - s)).
  - s=0 gives cur.
  - s=1 gives {cur[30:0], prev_c[31]}.
  - prev_c <= cur on every emission of channel c, including idle words.
- Bitslip:
  - A pulse sets pending_c.
  - At the next emission of channel c, slip_c increments by 1 modulo 32 (31 -> 0) and the new value is used for that emission.
  - Multiple pulses before that emission collapse to one increment.
  - A pulse arriving in the same cycle as the emission is applied at the following emission.
  - A pulse during reset is discarded.
- Wrap 31->0 drops 31 bits of history. Output stays word-continuous; no bits are duplicated.

Test Plan:
1. Reset, no traffic -> mgtword_o alternates shift of IDLE (=32'hAAAA_AAAA) with slot_b_o 0/1; underflow_o pulses every 2nd cycle; pair_ready_o=1.
2. Push pairs (A=32'h1000_000k, B=32'h2000_000k), k=0..7 at one per 2 cycles -> output 1000_0000, 2000_0000, 1000_0001, 2000_0001 ... with no underflow after the first pair; first A word one or two cycles after acceptance, depending on slot phase.
3. Burst 6 pairs back-to-back, FIFO_DEPTH=4 -> pair_ready_o drops when level=4; accepted pairs emitted in order, none lost or duplicated; level 4->3 on each pop.
4. Stream A=32'hFFFF_FFFF after A=0, single bitslip_a_i pulse -> slip_a_o=1; next A word = 32'hFFFF_FFFE; B stream unaffected.
5. 32 bitslip_b_i pulses, each applied on a separate B emission -> slip_b_o counts 1..31 then 0; a pulse coinciding with a B emission takes effect one B word later.
6. Assert reset while FIFO holds 3 pairs and after an A word is out -> next cycle mgtword_o=IDLE, level=0, slips=0; the held B word is never emitted.
